// File: rtl/systolic_pkg.sv
// ============================================================================
// Module  : systolic_pkg
// Brief   : Shared FSM encoding, accumulator sizing and slice-index helpers
//           for the systolic_matmul_param array.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Wide enough that N full-scale signed products never overflow.
    function automatic int acc_w_default(input int data_w, input int n);
        return 2 * data_w + $clog2(n);
    endfunction

    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

    function automatic int c_lsb(input int i, input int j, input int n, input int w);
        return (i * n + j) * w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_pe.sv
// ============================================================================
// Module  : systolic_pe
// Brief   : Output-stationary MAC cell; forwards a right and b down by one
//           register. Saturating accumulate when SYSTOLIC_SAT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
`ifdef SYSTOLIC_SAT_EN
    ,
    parameter int SAT_W  = ACC_W
`endif
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     clear,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic signed [DATA_W-1:0] b_out,
    output logic signed [ACC_W-1:0]  acc
`ifdef SYSTOLIC_SAT_EN
    ,
    output logic                     sat
`endif
);

    logic signed [DATA_W-1:0]   a_q, b_q;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [2*DATA_W-1:0] prod_w;
    logic signed [ACC_W-1:0]    prod_ext_w;

    assign prod_w     = a_in * b_in;
    assign prod_ext_w = {{(ACC_W-2*DATA_W){prod_w[2*DATA_W-1]}}, prod_w};

`ifdef SYSTOLIC_SAT_EN
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((64'sd1 <<< (SAT_W-1)) - 64'sd1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_W:0] sum_w;
    logic                  clip_w;
    logic                  sat_q;

    // One guard bit keeps the raw sum exact before clamping.
    assign sum_w = {acc_q[ACC_W-1], acc_q} + {prod_ext_w[ACC_W-1], prod_ext_w};

    always_comb begin
        clip_w = 1'b0;
        acc_d  = sum_w[ACC_W-1:0];
        if (sum_w > SAT_MAX) begin
            clip_w = 1'b1;
            acc_d  = SAT_MAX[ACC_W-1:0];
        end else if (sum_w < SAT_MIN) begin
            clip_w = 1'b1;
            acc_d  = SAT_MIN[ACC_W-1:0];
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset || clear) begin
            sat_q <= 1'b0;
        end else if (enable) begin
            sat_q <= sat_q | clip_w;
        end
    end

    assign sat = sat_q;
`else
    assign acc_d = acc_q + prod_ext_w;
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (enable) begin
            a_q   <= a_in;
            b_q   <= b_in;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

`default_nettype wire

// File: rtl/systolic_matmul_param.sv
// ============================================================================
// Module  : systolic_matmul_param
// Brief   : N x N output-stationary signed systolic multiplier C = A x B with
//           input skew, start/valid handshake and registered result bus.
//           Optional macro SYSTOLIC_SAT_EN: saturating accumulators + o_sat.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_matmul_param
    import systolic_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = acc_w_default(DATA_W, N)
`ifdef SYSTOLIC_SAT_EN
    ,
    parameter int SAT_W  = ACC_W
`endif
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_valid,
    input  logic [N*DATA_W-1:0]    i_a_full,
    input  logic [N*DATA_W-1:0]    i_b_full,
    output logic                   o_busy,
    output logic                   o_valid,
    output logic [N*N*ACC_W-1:0]   o_c_full
`ifdef SYSTOLIC_SAT_EN
    ,
    output logic                   o_sat
`endif
);

    localparam int BEAT_W  = $clog2(N);
    localparam int FLUSH_W = $clog2(2*N);

    state_e               state_q, state_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [FLUSH_W-1:0]   flush_q, flush_d;
    logic [N*N*ACC_W-1:0] c_q;
    logic [N*N*ACC_W-1:0] acc_flat_w;
    logic                 start_w, take_w, capture_w, busy_w;

    logic signed [DATA_W-1:0] a_lane_w [N];
    logic signed [DATA_W-1:0] b_lane_w [N];
    logic signed [DATA_W-1:0] a_h_w    [N][N];
    logic signed [DATA_W-1:0] b_v_w    [N][N];
    logic signed [ACC_W-1:0]  acc_w    [N][N];
`ifdef SYSTOLIC_SAT_EN
    logic [N*N-1:0]           sat_w;
    logic                     sat_q;
`endif

    assign start_w   = (state_q == ST_IDLE) && i_start;
    assign take_w    = (state_q == ST_LOAD) && i_valid;
    assign capture_w = (state_q == ST_FLUSH) && (flush_q == FLUSH_W'(2*N-2));
    assign busy_w    = (state_q == ST_LOAD) || (state_q == ST_FLUSH);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        flush_d = flush_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                    beat_d  = '0;
                end
            end
            ST_LOAD: begin
                if (i_valid) begin
                    if (beat_q == BEAT_W'(N-1)) begin
                        state_d = ST_FLUSH;
                        beat_d  = '0;
                        flush_d = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (capture_w) begin
                    state_d = ST_DONE;
                    flush_d = '0;
                end else begin
                    flush_d = flush_q + FLUSH_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
        end
    end

    // Lane k is delayed k cycles so a and b of one beat meet at every PE.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [DATA_W-1:0] a_inj_w, b_inj_w;
        assign a_inj_w = take_w ? i_a_full[lane_lsb(i, DATA_W) +: DATA_W] : '0;
        assign b_inj_w = take_w ? i_b_full[lane_lsb(i, DATA_W) +: DATA_W] : '0;

        if (i == 0) begin : g_direct
            assign a_lane_w[i] = a_inj_w;
            assign b_lane_w[i] = b_inj_w;
        end else begin : g_skew
            logic signed [DATA_W-1:0] a_sr_q [i];
            logic signed [DATA_W-1:0] b_sr_q [i];
            always_ff @(posedge i_clock) begin
                if (!i_reset) begin
                    for (int s = 0; s < i; s++) begin
                        a_sr_q[s] <= '0;
                        b_sr_q[s] <= '0;
                    end
                end else begin
                    a_sr_q[0] <= a_inj_w;
                    b_sr_q[0] <= b_inj_w;
                    for (int s = 1; s < i; s++) begin
                        a_sr_q[s] <= a_sr_q[s-1];
                        b_sr_q[s] <= b_sr_q[s-1];
                    end
                end
            end
            assign a_lane_w[i] = a_sr_q[i-1];
            assign b_lane_w[i] = b_sr_q[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [DATA_W-1:0] a_w, b_w;
            if (j == 0) begin : g_a_edge
                assign a_w = a_lane_w[i];
            end else begin : g_a_chain
                assign a_w = a_h_w[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_w = b_lane_w[j];
            end else begin : g_b_chain
                assign b_w = b_v_w[i-1][j];
            end

            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
`ifdef SYSTOLIC_SAT_EN
                ,
                .SAT_W  (SAT_W)
`endif
            ) u_pe (
                .i_clock (i_clock),
                .i_reset (i_reset),
                .clear   (start_w),
                .enable  (busy_w),
                .a_in    (a_w),
                .b_in    (b_w),
                .a_out   (a_h_w[i][j]),
                .b_out   (b_v_w[i][j]),
                .acc     (acc_w[i][j])
`ifdef SYSTOLIC_SAT_EN
                ,
                .sat     (sat_w[i*N+j])
`endif
            );

            assign acc_flat_w[c_lsb(i, j, N, ACC_W) +: ACC_W] = acc_w[i][j];
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            c_q <= '0;
        end else if (capture_w) begin
            c_q <= acc_flat_w;
        end
    end

`ifdef SYSTOLIC_SAT_EN
    always_ff @(posedge i_clock) begin
        if (!i_reset || start_w) begin
            sat_q <= 1'b0;
        end else if (capture_w) begin
            sat_q <= |sat_w;
        end
    end
    assign o_sat = sat_q;
`endif

    assign o_c_full = c_q;
    assign o_busy   = busy_w;
    assign o_valid  = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_systolic_matmul_param.sv
// ============================================================================
// Module  : tb_systolic_matmul_param
// Brief   : Directed self-checking bench for systolic_matmul_param (N=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_matmul_param;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 18;
`ifdef SYSTOLIC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              i_clock = 1'b0;
    logic              i_reset;
    logic              i_start;
    logic              i_valid;
    logic [N*DW-1:0]   i_a_full;
    logic [N*DW-1:0]   i_b_full;
    logic              o_busy;
    logic              o_valid;
    logic [N*N*AW-1:0] o_c_full;
`ifdef SYSTOLIC_SAT_EN
    logic              o_sat;
`endif

    int checks = 0;
    int errors = 0;
    int a_m   [N][N];
    int b_m   [N][N];
    int c_exp [N][N];
    bit sat_exp;

    always #5 i_clock = ~i_clock;

    systolic_matmul_param #(
        .N      (N),
        .DATA_W (DW)
`ifdef SYSTOLIC_SAT_EN
        ,
        .SAT_W  (16)
`endif
    ) dut (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_valid  (i_valid),
        .i_a_full (i_a_full),
        .i_b_full (i_b_full),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_c_full (o_c_full)
`ifdef SYSTOLIC_SAT_EN
        ,
        .o_sat    (o_sat)
`endif
    );

    task automatic tick;
        @(posedge i_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] get_c(input int i, input int j);
        logic signed [AW-1:0] v;
        v = o_c_full[(i*N+j)*AW +: AW];
        return v;
    endfunction

    task automatic check_c(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("%s_c%0d%0d", tag, i, j), get_c(i, j), c_exp[i][j]);
    endtask

    task automatic drive_beat(input int k);
        i_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            i_a_full[i*DW +: DW] = DW'(a_m[i][k]);
            i_b_full[i*DW +: DW] = DW'(b_m[k][i]);
        end
        tick();
        i_valid  = 1'b0;
        i_a_full = '0;
        i_b_full = '0;
    endtask

    task automatic start_and_load(input int gap, input bit poke, input string tag);
        i_start = 1'b1;
        if (poke) begin
            i_valid  = 1'b1;
            i_a_full = '1;
            i_b_full = '1;
        end
        tick();
        i_start  = 1'b0;
        i_valid  = 1'b0;
        i_a_full = '0;
        i_b_full = '0;
        chk({tag, "_busy_load"}, o_busy, 1);
        for (int k = 0; k < N; k++) begin
            if (poke) i_start = (k == 1);
            drive_beat(k);
            i_start = 1'b0;
            if (k < N-1) begin
                for (int g = 0; g < gap; g++) begin
                    i_a_full = {N{8'h55}};
                    i_b_full = {N{8'hA3}};
                    tick();
                end
                i_a_full = '0;
                i_b_full = '0;
            end
        end
    endtask

    task automatic run(input int gap, input bit poke, input int hold33, input string tag);
        int n;
        start_and_load(gap, poke, tag);
        n = 1;
        while (o_valid !== 1'b1 && n < 40) begin
            if (poke && n <= 2) begin
                i_start  = 1'b1;
                i_valid  = 1'b1;
                i_a_full = '1;
                i_b_full = '1;
                chk({tag, "_hold"}, get_c(3, 3), hold33);
            end else begin
                i_start  = 1'b0;
                i_valid  = 1'b0;
                i_a_full = '0;
                i_b_full = '0;
            end
            tick();
            n++;
        end
        i_start  = 1'b0;
        i_valid  = 1'b0;
        i_a_full = '0;
        i_b_full = '0;
        chk({tag, "_latency"}, n, 2*N);
        chk({tag, "_valid"}, o_valid, 1);
        check_c(tag);
`ifdef SYSTOLIC_SAT_EN
        chk({tag, "_sat"}, o_sat, sat_exp);
`endif
        tick();
        chk({tag, "_valid_pulse"}, o_valid, 0);
        chk({tag, "_busy_idle"}, o_busy, 0);
    endtask

    task automatic set_identity;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_m[i][j]   = (i == j) ? 1 : 0;
                b_m[i][j]   = i*N + j + 1;
                c_exp[i][j] = i*N + j + 1;
            end
    endtask

    initial begin
        int seen;
        i_reset  = 1'b0;
        i_start  = 1'b0;
        i_valid  = 1'b0;
        i_a_full = '0;
        i_b_full = '0;
        sat_exp  = 1'b0;
        tick();
        tick();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) c_exp[i][j] = 0;
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        check_c("rst");
        i_reset = 1'b1;
        tick();

        // Identity A: C must equal B.
        set_identity();
        run(0, 1'b0, 0, "ident");

        // Signed extremes.
        sat_exp = SAT;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_m[i][j]   = -128;
                b_m[i][j]   = -128;
                c_exp[i][j] = SAT ? 32767 : 65536;
            end
        run(0, 1'b0, 0, "negneg");
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                b_m[i][j]   = 127;
                c_exp[i][j] = SAT ? -32768 : -65024;
            end
        run(0, 1'b0, 0, "negpos");
        sat_exp = 1'b0;

        // Gapped beats with junk on the data lines while i_valid is low.
        set_identity();
        run(2, 1'b0, 0, "gap");

        // Ignored i_start/i_valid; previous C[3][3]=16 must hold until DONE.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_m[i][j] = 1;
                b_m[i][j] = i*N + j + 1;
                c_exp[i][j] = 28 + 4*j;
            end
        run(0, 1'b1, 16, "ignore");

        // Reset in the middle of FLUSH aborts the product.
        set_identity();
        start_and_load(0, 1'b0, "abort");
        tick();
        tick();
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        chk("abort_busy", o_busy, 0);
        chk("abort_valid", o_valid, 0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) c_exp[i][j] = 0;
        check_c("abort");
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (o_valid === 1'b1) seen++;
            tick();
        end
        chk("abort_no_valid", seen, 0);
        set_identity();
        run(0, 1'b0, 0, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
